// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_dbus_if.sv
// Data-bus req/ack channel between the LSU (master) and memory (slave).
interface lsu_dbus_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: funct3 + byte offset -> byte enables, replicated store data, misalignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        be         = 4'hF;
        wdata      = wd;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << offset;
                wdata = {4{wd[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << offset;
                wdata      = {2{wd[15:0]}};
                misaligned = offset[0];
            end
            default: begin
                // F3_W and any unlisted encoding are treated as a full word
                be         = 4'hF;
                misaligned = |offset;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dbus.sv
// M-stage load/store unit: stalls the pipe while a req/ack data-bus access runs.
// Optional LSU_TIMEOUT_EN aborts a request after TIMEOUT_CYC unacked REQ cycles.
module lsu_dbus
    import lsu_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        misalign_err,
    output logic        bus_err,
    lsu_dbus_if.master  dbus
);

    lsu_state_t  state, state_nxt;
    logic        access;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic        stall, mis_pulse, start, finish, timed_out;
    logic [1:0]  offset_q;
    logic        load_q;

    assign access = MemReadM | MemWriteM;

    lsu_align u_align (
        .funct3     (funct3M),
        .offset     (ALUResultM[1:0]),
        .wd         (WriteDataM),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_mis)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_RDATA, TIMEOUT_CYC[0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mis_pulse = 1'b0;
        start     = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: if (access) begin
                if (al_mis) begin
                    mis_pulse = 1'b1;
                end else begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                // ack beats a simultaneous timeout
                if (dbus.dbus_ack) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            // retiring instruction still shows access here; never restart from DONE
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // reset must release the pipeline immediately even while access is held
    assign StallM       = stall & ~rst;
    assign misalign_err = mis_pulse & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_be    <= '0;
            dbus.dbus_wdata <= '0;
            offset_q        <= '0;
            load_q          <= 1'b0;
            ReadData        <= '0;
        end else begin
            if (start) begin
                dbus.dbus_req   <= 1'b1;
                dbus.dbus_we    <= ~MemReadM;
                dbus.dbus_addr  <= {ALUResultM[31:2], 2'b00};
                dbus.dbus_be    <= al_be;
                dbus.dbus_wdata <= al_wdata;
                offset_q        <= ALUResultM[1:0];
                load_q          <= MemReadM;
            end
            if (finish) begin
                dbus.dbus_req <= 1'b0;
                if (load_q) ReadData <= dbus.dbus_rdata >> {offset_q, 3'b000};
            end
            if (timed_out) begin
                dbus.dbus_req <= 1'b0;
                if (load_q) ReadData <= ERR_RDATA;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timed_out;
            if (start)
                cnt <= '0;
            else if (state == REQ && !dbus.dbus_ack)
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_dbus.sv
// Randomized bench for lsu_dbus with a lane-arithmetic reference model and a scripted bus slave.
module tb_lsu_dbus;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  funct3M;
    logic [31:0] ReadData;
    logic        StallM, misalign_err, bus_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rd = '0;

`ifdef LSU_TIMEOUT_EN
    localparam int MAXD = 3;
`else
    localparam int MAXD = 6;
`endif

    always #5 clk = ~clk;

    lsu_dbus_if bus ();

    lsu_dbus #(.TIMEOUT_CYC(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .funct3M      (funct3M),
        .ReadData     (ReadData),
        .StallM       (StallM),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dbus         (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // access size in bytes; lane i of the bus carries store byte (i mod size)
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                  output logic mis, output logic [3:0] be, output logic [31:0] wdat);
        int size;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = (a % size) != 0;
        be   = 4'(((1 << size) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % size) +: 8];
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        MemReadM = 1'b0; MemWriteM = 1'b0;
        bus.dbus_ack = 1'($urandom % 2); bus.dbus_rdata = $urandom;
        #1;
        chk("idle_stall", StallM, 0);
        chk("idle_req", bus.dbus_req, 0);
        chk("idle_rdata", ReadData, exp_rd);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int delay, input logic [31:0] rdata);
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdat;
        int          stalls;
        model(f3, a, wd, mis, be, wdat);
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        bus.dbus_ack = 1'($urandom % 2); bus.dbus_rdata = $urandom;
        #1;
        if (mis) begin
            chk("mis_pulse", misalign_err, 1);
            chk("mis_stall", StallM, 0);
            chk("mis_req", bus.dbus_req, 0);
            @(negedge clk);
            MemReadM = 1'b0; MemWriteM = 1'b0; bus.dbus_ack = 1'b0;
            #1;
            chk("mis_req_after", bus.dbus_req, 0);
            chk("mis_pulse_end", misalign_err, 0);
            return;
        end
        stalls = 0;
        chk("idle_stall_start", StallM, 1);
        chk("no_mis", misalign_err, 0);
        if (StallM) stalls++;
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            bus.dbus_ack   = (k == delay);
            bus.dbus_rdata = (k == delay) ? rdata : $urandom;
            #1;
            chk("req", bus.dbus_req, 1);
            chk("addr", bus.dbus_addr, {a[31:2], 2'b00});
            chk("be", bus.dbus_be, be);
            chk("we", bus.dbus_we, !rd);
            chk("wdata", bus.dbus_wdata, wdat);
            chk("bus_err_req", bus_err, 0);
            if (StallM) stalls++;
        end
        @(negedge clk);
        bus.dbus_ack = 1'($urandom % 2); bus.dbus_rdata = $urandom;
        #1;
        if (rd) exp_rd = rdata >> (8 * a[1:0]);
        chk("done_stall", StallM, 0);
        chk("done_req", bus.dbus_req, 0);
        chk("done_bus_err", bus_err, 0);
        chk("readdata", ReadData, exp_rd);
        chk("stall_cycles", stalls, delay + 2);
    endtask

    initial begin
        logic [2:0]  f3s [5];
        logic        rd, wr;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h1000_0008;
        WriteDataM = '0; funct3M = 3'b010;
        bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_req", bus.dbus_req, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_rdata", ReadData, 0);
        chk("rst_addr", bus.dbus_addr, 0);
        chk("rst_be", bus.dbus_be, 0);
        chk("rst_bus_err", bus_err, 0);
        MemReadM = 1'b0;
        rst = 1'b0;

        do_access(1, 0, 3'b010, 32'h1000_0008, 32'h0, 0, 32'h1234_5678);
        do_access(1, 0, 3'b000, 32'h1000_0003, 32'h0, 3, 32'hAB00_0000);
        do_access(0, 1, 3'b001, 32'h1000_0002, 32'hFFFF_BEEF, 1, 32'h5555_5555);
        do_access(1, 0, 3'b010, 32'h1000_0001, 32'h0, 0, 32'h0);
        do_access(1, 1, 3'b101, 32'h2000_0006, 32'hCAFE_F00D, 2, 32'h8765_4321);
        idle_cycle();

        // reset in the middle of REQ
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h3000_0004;
        bus.dbus_ack = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_req", bus.dbus_req, 1);
        rst = 1'b1;
        #1;
        exp_rd = '0;
        chk("mid_rst_req", bus.dbus_req, 0);
        chk("mid_rst_stall", StallM, 0);
        chk("mid_rst_rdata", ReadData, exp_rd);
        @(negedge clk);
        MemReadM = 1'b0;
        rst = 1'b0;
        idle_cycle();
        do_access(1, 0, 3'b001, 32'h3000_0002, 32'h0, 1, 32'h9ABC_0000);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h4000_0000;
        bus.dbus_ack = 1'b0;
        #1 chk("to_idle_stall", StallM, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("to_req", bus.dbus_req, 1);
            chk("to_stall", StallM, 1);
            chk("to_bus_err_early", bus_err, 0);
        end
        @(negedge clk); #1;
        exp_rd = 32'hDEAD_BEEF;
        chk("to_bus_err", bus_err, 1);
        chk("to_req_drop", bus.dbus_req, 0);
        chk("to_done_stall", StallM, 0);
        chk("to_rdata", ReadData, exp_rd);
        idle_cycle();
        chk("to_bus_err_end", bus_err, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 4 == 0) : 1'b1;
            do_access(rd, wr, f3s[$urandom % 5], $urandom, $urandom,
                      int'($urandom_range(0, MAXD)), $urandom);
            if ($urandom % 4 == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
